// File: rtl/softermax_vec_packer.sv
// Serial-to-vector packer feeding the softmax stage: collects scores into lanes,
// tracks the running max, and holds the finished vector until it is taken.
module softermax_vec_packer #(
    parameter int VEC_SIZE = 10,
    parameter int BW       = 8,
    parameter int FW       = 2,
    parameter int CNT_W    = $clog2(VEC_SIZE + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BW-1:0]       in_data,
    input  logic                in_last,
    output logic                vec_valid,
    input  logic                vec_ready,
    output logic [BW-1:0]       vec_data [VEC_SIZE-1:0],
    output logic [BW-1:0]       vec_max,
    output logic [CNT_W-1:0]    vec_count
);

    // The fraction width only fixes the score format; it must leave a sign bit.
    if (FW > BW - 1) begin : g_fw_range_check
        $error("softermax_vec_packer: FW must be smaller than BW");
    end

    localparam logic [BW-1:0]    PAD      = {1'b1, {(BW-1){1'b0}}};
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(VEC_SIZE - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BW-1:0]     max_q, max_d;
    logic [BW-1:0]     lane_q [VEC_SIZE-1:0];
    logic              accept;

    assign in_ready  = (state_q == FILL);
    assign vec_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        max_d   = max_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (idx_q == '0) begin
                        max_d = in_data;
                    end else if ($signed(in_data) > $signed(max_q)) begin
                        max_d = in_data;
                    end
                    if ((idx_q == IDX_LAST) || in_last) begin
                        count_d = idx_q + CNT_W'(1);
                        state_d = HOLD;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    count_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            count_q <= '0;
            max_q   <= PAD;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    // Lane storage is unreset; lanes at or beyond count are masked to PAD below.
    always_ff @(posedge clk) begin
        if (accept) begin
            lane_q[idx_q] <= in_data;
        end
    end

    for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lane
        assign vec_data[g] = (CNT_W'(g) < count_q) ? lane_q[g] : PAD;
    end

    assign vec_max   = max_q;
    assign vec_count = count_q;

endmodule

// File: tb/tb_softermax_vec_packer.sv
// Directed bench for softermax_vec_packer: table of whole vectors plus
// hand-written backpressure, reset and streaming sequences.
module tb_softermax_vec_packer;

    localparam int VS = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       vec_valid;
    logic       vec_ready;
    logic [7:0] vec_data [VS-1:0];
    logic [7:0] vec_max;
    logic [3:0] vec_count;

    int errors = 0;
    int checks = 0;

    softermax_vec_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_max   (vec_max),
        .vec_count (vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [7:0] d [VS];
        logic       last;
        int         exp_cnt;
        logic [7:0] exp_max;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one element and wait (bounded) until it is accepted.
    task automatic push(input logic [7:0] d, input logic last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        check("drain_vec_valid", int'(vec_valid), 0);
        check("drain_in_ready", int'(in_ready), 1);
        check("drain_count", int'(vec_count), 0);
    endtask

    logic acc;
    int   sent, cyc, nvec;

    initial begin
        tbl[0].n = 10; tbl[0].last = 1'b0; tbl[0].exp_cnt = 10; tbl[0].exp_max = 8'h24;
        tbl[0].d = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
        tbl[1].n = 3;  tbl[1].last = 1'b1; tbl[1].exp_cnt = 3;  tbl[1].exp_max = 8'h0C;
        tbl[1].d = '{8'hF8, 8'h0C, 8'h02, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].n = 4;  tbl[2].last = 1'b1; tbl[2].exp_cnt = 4;  tbl[2].exp_max = 8'hFC;
        tbl[2].d = '{8'hF0, 8'hFC, 8'hFC, 8'h81, 0, 0, 0, 0, 0, 0};
        tbl[3].n = 1;  tbl[3].last = 1'b1; tbl[3].exp_cnt = 1;  tbl[3].exp_max = 8'h85;
        tbl[3].d = '{8'h85, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].n = 10; tbl[4].last = 1'b1; tbl[4].exp_cnt = 10; tbl[4].exp_max = 8'h7F;
        tbl[4].d = '{8'h80, 8'h90, 8'h7F, 8'h00, 8'h7F, 8'h81, 8'hFF, 8'h01, 8'h7E, 8'hC0};
        tbl[5].n = 3;  tbl[5].last = 1'b1; tbl[5].exp_cnt = 3;  tbl[5].exp_max = 8'h50;
        tbl[5].d = '{8'h50, 8'h10, 8'h20, 0, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_vec_valid", int'(vec_valid), 0);
        check("rst_count", int'(vec_count), 0);
        check("rst_max", int'(vec_max), 8'h80);
        check("rst_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 6; v++) begin
            for (int j = 0; j < tbl[v].n; j++)
                push(tbl[v].d[j], tbl[v].last && (j == tbl[v].n - 1));
            check($sformatf("v%0d_vec_valid", v), int'(vec_valid), 1);
            check($sformatf("v%0d_in_ready", v), int'(in_ready), 0);
            check($sformatf("v%0d_count", v), int'(vec_count), tbl[v].exp_cnt);
            check($sformatf("v%0d_max", v), int'(vec_max), int'(tbl[v].exp_max));
            for (int i = 0; i < VS; i++)
                check($sformatf("v%0d_lane%0d", v, i), int'(vec_data[i]),
                      (i < tbl[v].n) ? int'(tbl[v].d[i]) : 8'h80);
            drain();
        end

        // Backpressure: held outputs stay put and the pending element waits.
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        in_valid = 1'b1; in_data = 8'h33; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_vec_valid", int'(vec_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_count", int'(vec_count), 2);
            check("bp_max", int'(vec_max), 8'h22);
            check("bp_lane0", int'(vec_data[0]), 8'h11);
            check("bp_lane1", int'(vec_data[1]), 8'h22);
        end
        vec_ready = 1'b1;
        @(posedge clk); #1;
        vec_ready = 1'b0;
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_vec_valid", int'(vec_valid), 0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b1);
        check("bp_next_count", int'(vec_count), 2);
        check("bp_next_lane0", int'(vec_data[0]), 8'h33);
        check("bp_next_lane1", int'(vec_data[1]), 8'h44);
        check("bp_next_max", int'(vec_max), 8'h44);
        drain();

        // Reset after six accepts discards the partial vector.
        for (int j = 0; j < 6; j++) push(8'(8'h30 + j), 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_vec_valid", int'(vec_valid), 0);
        check("mid_rst_count", int'(vec_count), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        push(8'h05, 1'b0);
        push(8'h06, 1'b1);
        check("mid_rst_count2", int'(vec_count), 2);
        check("mid_rst_max", int'(vec_max), 8'h06);
        for (int i = 0; i < VS; i++)
            check($sformatf("mid_rst_lane%0d", i), int'(vec_data[i]),
                  (i == 0) ? 8'h05 : (i == 1) ? 8'h06 : 8'h80);
        drain();

        // Streaming 25 elements with vec_ready tied high: 2 full vectors, 2 bubbles.
        vec_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 8'h00;
        sent = 0; cyc = 0; nvec = 0;
        while (sent < 25 && cyc < 100) begin
            acc = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_data = 8'(sent);
            end
            if (vec_valid) begin
                check("b2b_count", int'(vec_count), 10);
                check("b2b_lane0", int'(vec_data[0]), nvec * 10);
                check("b2b_lane9", int'(vec_data[9]), nvec * 10 + 9);
                nvec++;
            end
        end
        in_valid = 1'b0;
        vec_ready = 1'b0;
        check("b2b_sent", sent, 25);
        check("b2b_cycles", cyc, 27);
        check("b2b_nvec", nvec, 2);
        check("b2b_in_ready", int'(in_ready), 1);
        check("b2b_vec_valid", int'(vec_valid), 0);
        push(8'd25, 1'b1);
        check("b2b_tail_count", int'(vec_count), 6);
        check("b2b_tail_lane0", int'(vec_data[0]), 8'h14);
        check("b2b_tail_lane5", int'(vec_data[5]), 8'h19);
        check("b2b_tail_lane6", int'(vec_data[6]), 8'h80);
        check("b2b_tail_max", int'(vec_max), 8'h19);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softermax_vec_packer.md
Name: softermax_vec_packer

Overview:
- Upstream feeder for softermax_wrapper.
- Accepts a serial stream of signed BW-bit fixed-point scores (FW fraction bits) over a valid/ready handshake and packs them into a VEC_SIZE-wide vector.
- Tracks the running maximum of the vector during fill.
- Presents the completed vector, its maximum and its element count to the softmax stage, holding them stable until that stage accepts.
- Short vectors are padded with the most negative code so padded lanes contribute ~0 probability.

Parameters:
VEC_SIZE, 10, number of lanes per output vector
BW, 8, element width (signed two's complement)
FW, 2, fraction bits of element (informational; no arithmetic depends on it)
CNT_W, $clog2(VEC_SIZE+1), width of element count

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_data/in_last valid this cycle
in_ready  output  1  packer can accept an element
in_data  input  BW  signed score element
in_last  input  1  element is final of current vector
vec_valid  output  1  packed vector available
vec_ready  input  1  downstream accepts vector
vec_data  output  VEC_SIZE x BW  unpacked array [VEC_SIZE-1:0], lane i = i-th accepted element
vec_max  output  BW  signed max over valid lanes
vec_count  output  CNT_W  number of valid lanes, 1..VEC_SIZE

Behaviour:
- Reset (rst_n low at clk edge):
  - state=FILL, idx=0, vec_valid=0, vec_count=0, vec_max=PAD, in_ready=1 after reset releases.
  - Applies regardless of current state; a partially filled or held vector is discarded.
- PAD = {1'b1,{BW-1{1'b0}}} (8'h80 at default).
- States:
  - FILL: in_ready=1, vec_valid=0.
  - HOLD: in_ready=0, vec_valid=1.
- FILL, accept = in_valid && in_ready:
  - buf[idx] <= in_data.
  - If idx==0: max <= in_data. Otherwise: max <= (signed in_data > max) ? in_data : max. Ties keep the old value.
  - If idx==VEC_SIZE-1 or in_last: count <= idx+1, go HOLD. Otherwise idx <= idx+1.
- HOLD:
  - vec_valid=1 the cycle after the final element is accepted (latency 1).
  - vec_data, vec_max and vec_count are stable while vec_valid && !vec_ready.
  - On vec_valid && vec_ready: go FILL, idx <= 0, count <= 0. in_ready=1 in the next cycle.
  - in_valid during HOLD is ignored; the upstream element is not consumed.
- Output lanes: vec_data[i] = (i < count) ? buf[i] : PAD. Combinational from registers; no combinational path from in_* or vec_ready to vec_data/vec_max.
- in_ready depends only on state. No combinational in_valid->in_ready path.
- in_last on the VEC_SIZE-th element: same as a full vector, count=VEC_SIZE.
- More than VEC_SIZE elements without in_last: the vector closes at VEC_SIZE. The next element starts a new vector (no error flag).
- in_last on the first element: count=1, max=that element, lanes 1..VEC_SIZE-1 = PAD.
- Buffer registers need no reset. Outputs are defined via count/state.
- Throughput: one element per cycle in FILL. One bubble cycle per vector (HOLD->FILL).

Test Plan:
- Full vector:
  - Stimulus: in_valid continuous, in_data 0x00,0x04,0x08,...,0x24 (0.0..9.0 in Q6.2).
  - Response: vec_valid one cycle after the 10th accept; vec_data lanes match; vec_max=0x24; vec_count=10; in_ready=0 while held.
- Short vector:
  - Stimulus: 0xF8,0x0C,0x02 with in_last on the 3rd.
  - Response: vec_count=3; vec_max=0x0C; lanes 3..9 = 0x80.
- Backpressure:
  - Stimulus: vec_ready low for 5 cycles after vec_valid, in_valid held high.
  - Response: outputs stable; no element accepted. After vec_ready=1, in_ready returns next cycle and the first pending element lands in lane 0.
- All-negative and tie:
  - Stimulus: 0xF0,0xFC,0xFC,0x81 with in_last.
  - Response: vec_max=0xFC; count=4.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge after 6 accepts.
  - Response: vec_valid=0, count=0; next vector of 2 elements gives count=2 with no stale lanes (lanes 2..9 = 0x80).
- Back-to-back vectors:
  - Stimulus: 25 consecutive elements, no in_last, vec_ready tied 1.
  - Response: two vectors of count 10, then the third vector holds 5 elements (still in FILL); 1 bubble cycle between vectors.
